// File: rtl/rr_arb_4_1.sv
// Four-requester round-robin arbiter with a one-entry registered valid/ready
// output stage. Produces the 2-bit mux select (00=d0 .. 11=d3) alongside the
// already-muxed word.
// Optional build macro: RR_ARB_FIXED_PRIO_EN replaces the rotating pointer
// with fixed lowest-index-wins priority.
module rr_arb_4_1 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [1:0]   out_sel_q, out_sel_d;
  logic [1:0]   grant;
  logic [W-1:0] grant_data;
  logic         load;

  // Register is free when empty or draining this cycle; rst_n gate keeps
  // in_ready low throughout reset.
  assign load = rst_n & (|in_valid) & (~out_valid_q | out_ready);

`ifdef RR_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest asserted index wins.
  always_comb begin
    grant = 2'd0;
    casez (in_valid)
      4'b???1: grant = 2'd0;
      4'b??10: grant = 2'd1;
      4'b?100: grant = 2'd2;
      4'b1000: grant = 2'd3;
      default: grant = 2'd0;
    endcase
  end
`else
  logic [1:0] ptr_q, ptr_d;

  // Round-robin search starting just after the last grant, wrapping mod 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    grant = ptr_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Pointer follows the winner only when a word is actually captured.
  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = grant;
  end

  // Last-grant pointer; reset to 3 so requester 0 leads after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd3;
    else        ptr_q <= ptr_d;
  end
`endif

  // Data mux using the same select encoding as the downstream stage.
  always_comb begin
    grant_data = in_data0;
    unique case (grant)
      2'd0: grant_data = in_data0;
      2'd1: grant_data = in_data1;
      2'd2: grant_data = in_data2;
      2'd3: grant_data = in_data3;
      default: grant_data = in_data0;
    endcase
  end

  // One-hot accept to the winner, only when the word can be captured.
  always_comb begin
    in_ready = 4'b0000;
    if (load) in_ready[grant] = 1'b1;
  end

  // Output stage next state: load wins over drain so there is no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Directed, table-driven bench for rr_arb_4_1 (W=4, data A/B/C/D on ports 0..3).
module tb_rr_arb_4_1;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arb_4_1 #(.W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data0 (in_data0),
    .in_data1 (in_data1),
    .in_data2 (in_data2),
    .in_data3 (in_data3),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;      // in_valid
    logic       ordy;   // out_ready
    logic [3:0] rdy;    // expected in_ready before the edge
    logic       ovld;   // expected out_valid after the edge
    logic [1:0] sel;    // expected out_sel after the edge
    logic [3:0] data;   // expected out_data after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic ordy, input logic [3:0] rdy,
                     input logic ovld, input logic [1:0] sel, input logic [3:0] data);
    vec_t e;
    e.v = v; e.ordy = ordy; e.rdy = rdy; e.ovld = ovld; e.sel = sel; e.data = data;
    vecs.push_back(e);
  endtask

  initial begin
`ifdef RR_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
    add(4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 4'hB);
`else
    // rotation from reset pointer 3
    add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
    add(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
    add(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC);
    add(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD);
    add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
    // skip idle requesters, wrap 2 -> 0
    add(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
    add(4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC);
    add(4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
    // idle: drain then hold empty
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'hA);
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'hA);
    // empty register loads even with out_ready low
    add(4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 4'hD);
    // backpressure for 3 cycles
    add(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 4'hD);
    add(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 4'hD);
    add(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 4'hD);
    // drain and load on the same edge, no bubble
    add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
    add(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 4'hA);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'hA);
`endif

    in_data0 = 4'hA; in_data1 = 4'hB; in_data2 = 4'hC; in_data3 = 4'hD;
    rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      in_valid  = vecs[i].v;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ovld));
      chk($sformatf("v%0d_out_sel", i),   32'(out_sel),   32'(vecs[i].sel));
      chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].data));
      @(negedge clk);
    end

    // Reset mid-stream while holding a word from requester 2
    in_valid = 4'b0100; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    chk("mid_pre_sel",   32'(out_sel),   32'd2);
    in_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sel",   32'(out_sel),   32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("mid_post_ready", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("mid_post_valid", 32'(out_valid), 32'd1);
    chk("mid_post_sel",   32'(out_sel),   32'd0);
    chk("mid_post_data",  32'(out_data),  32'hA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
